// File: rtl/phase_diff_multi.sv
`default_nettype none
// ============================================================================
// phase_diff_multi : per-channel averaged phase difference vs channel 0,
//                    unwrapped phase advance and sticky fault, streamed out.
// Rev 1.0
// ============================================================================
module phase_diff_multi #(
  parameter int DW      = 14,
  parameter int NCH     = 4,
  parameter int LOG_PER = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH*DW-1:0]        phase_in,
  input  logic [NCH-1:0]           fault_in,
  input  logic                     err_clr,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(NCH)-1:0]   res_ch,
  output logic [DW-1:0]            res_phdiff,
  output logic [DW+LOG_PER-1:0]    res_freq,
  output logic                     res_fault,
  output logic                     overrun,
  output logic                     err
);

  localparam int CW = $clog2(NCH);
  localparam int AW = DW + LOG_PER;
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WARM = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t             state_q;
  logic [DW-1:0]      p_q      [NCH];
  logic [DW-1:0]      p_prev_q [NCH];
  logic [AW-1:0]      acc_d_q  [NCH];
  logic [AW-1:0]      acc_s_q  [NCH];
  logic [DW-1:0]      snap_d_q [NCH];
  logic [AW-1:0]      snap_s_q [NCH];
  logic [NCH-1:0]     f_q, fault_acc_q, snap_f_q;
  logic [LOG_PER-1:0] cnt_q;
  logic [CW-1:0]      ch_q;
  logic               valid_q, overrun_q, err_q;

  logic [DW-1:0]      dif_d  [NCH];
  logic [DW-1:0]      step_d [NCH];
  logic [AW-1:0]      sum_d_d [NCH];
  logic [AW-1:0]      sum_s_d [NCH];
  logic               tick, beat, last_beat, take_snap;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      dif_d[k]   = p_q[k] - p_q[0];
      step_d[k]  = p_q[k] - p_prev_q[k];
      sum_d_d[k] = acc_d_q[k] + {{LOG_PER{dif_d[k][DW-1]}}, dif_d[k]};
      sum_s_d[k] = acc_s_q[k] + {{LOG_PER{step_d[k][DW-1]}}, step_d[k]};
    end
  end

  assign tick      = &cnt_q;
  assign beat      = valid_q & res_ready;
  assign last_beat = beat && (ch_q == LAST_CH);
  assign take_snap = tick && ((state_q == S_IDLE) || ((state_q == S_EMIT) && last_beat));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        p_q[k]      <= '0;
        p_prev_q[k] <= '0;
        acc_d_q[k]  <= '0;
        acc_s_q[k]  <= '0;
        snap_d_q[k] <= '0;
        snap_s_q[k] <= '0;
      end
      f_q         <= '0;
      fault_acc_q <= '0;
      snap_f_q    <= '0;
      cnt_q       <= '0;
      ch_q        <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      err_q       <= 1'b0;
      state_q     <= S_WARM;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        p_q[k]      <= phase_in[k*DW +: DW];
        p_prev_q[k] <= p_q[k];
        acc_d_q[k]  <= tick ? '0 : sum_d_d[k];
        acc_s_q[k]  <= tick ? '0 : sum_s_d[k];
        // floor(sum / 2^LOG_PER) truncated to DW bits is exactly the top DW bits
        if (take_snap) begin
          snap_d_q[k] <= sum_d_d[k][AW-1:LOG_PER];
          snap_s_q[k] <= sum_s_d[k];
        end
      end
      f_q         <= fault_in;
      fault_acc_q <= tick ? '0 : (fault_acc_q | f_q);
      if (take_snap) snap_f_q <= fault_acc_q | f_q;
      cnt_q     <= cnt_q + 1'b1;
      overrun_q <= tick && (state_q == S_EMIT) && !last_beat;
      if (beat && res_fault) err_q <= 1'b1;
      else if (err_clr)      err_q <= 1'b0;

      case (state_q)
        S_WARM: if (tick) state_q <= S_IDLE;
        S_IDLE: if (tick) begin
          state_q <= S_EMIT;
          valid_q <= 1'b1;
          ch_q    <= '0;
        end
        S_EMIT: if (beat) begin
          if (ch_q == LAST_CH) begin
            ch_q <= '0;
            // a tick on the final handshake starts the next emission directly
            if (!tick) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
            end
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: state_q <= S_WARM;
      endcase
    end
  end

  assign res_valid  = valid_q;
  assign res_ch     = ch_q;
  assign res_phdiff = snap_d_q[ch_q];
  assign res_freq   = snap_s_q[ch_q];
  assign res_fault  = snap_f_q[ch_q];
  assign overrun    = overrun_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_diff_multi.sv
`default_nettype none
// ============================================================================
// tb_phase_diff_multi : directed + randomized bench with a period-level model.
// Rev 1.0
// ============================================================================
module tb_phase_diff_multi;

  localparam int DW = 14, NCH = 4, LOG_PER = 4;
  localparam int AW = DW + LOG_PER;
  localparam int PER = 1 << LOG_PER;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] phase = '0;
  logic [NCH-1:0]    fault = '0;
  logic              err_clr = 1'b0;
  logic              ready = 1'b0;
  logic              res_valid, res_fault, overrun, err;
  logic [1:0]        res_ch;
  logic [DW-1:0]     res_phdiff;
  logic [AW-1:0]     res_freq;

  phase_diff_multi #(.DW(DW), .NCH(NCH), .LOG_PER(LOG_PER)) dut (
    .clk(clk), .rst(rst), .phase_in(phase), .fault_in(fault), .err_clr(err_clr),
    .res_valid(res_valid), .res_ready(ready), .res_ch(res_ch),
    .res_phdiff(res_phdiff), .res_freq(res_freq), .res_fault(res_fault),
    .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

  int vec = 0, miss = 0;
  // samples seen by the accumulator: index j is the j-th cycle after reset
  logic [NCH*DW-1:0] hist_p[$];
  logic [NCH-1:0]    hist_f[$];
  int cyc = 0, outstanding = 0, emit_per = 0, beat_ch = 0;
  logic err_exp = 1'b0, ovr_exp = 1'b0, fault_cur = 1'b0;
  // stimulus configuration
  int base[NCH], rate[NCH];
  int t = 0, rdy_pct = 100, lo_from = 0, lo_to = 0;
  int f_at1 = -1, f_at2 = -1, c_at1 = -1, c_at2 = -1;
  bit rnd_flt = 0, chk48 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int chan(input logic [NCH*DW-1:0] w, input int k);
    logic [DW-1:0] v;
    v = w[k*DW +: DW];
    return int'(v);
  endfunction

  function automatic int swrap(input int x);
    int y;
    y = ((x % (1 << DW)) + (1 << DW)) % (1 << DW);
    if (y >= (1 << (DW - 1))) y -= (1 << DW);
    return y;
  endfunction

  task automatic model(input int n, input int k, output logic [DW-1:0] phd,
                       output logic [AW-1:0] frq, output logic flt);
    longint sd, ss, q;
    int cur, rf, pv;
    sd = 0; ss = 0; flt = 1'b0;
    for (int j = PER * n; j < PER * n + PER; j++) begin
      cur = chan(hist_p[j], k);
      rf  = chan(hist_p[j], 0);
      pv  = (j == 0) ? 0 : chan(hist_p[j-1], k);
      sd += swrap(cur - rf);
      ss += swrap(cur - pv);
      flt |= hist_f[j][k];
    end
    q = sd / PER;
    if ((sd % PER) != 0 && sd < 0) q = q - 1;
    phd = q[DW-1:0];
    frq = ss[AW-1:0];
  endtask

  task automatic step();
    logic acc_now;
    logic [DW-1:0] phd;
    logic [AW-1:0] frq;
    logic flt;
    int x;
    acc_now = (outstanding > 0) && ready;
    @(posedge clk);
    if (rst) begin
      hist_p = {}; hist_f = {};
      hist_p.push_back('0); hist_f.push_back('0);
      cyc = 0; outstanding = 0; beat_ch = 0; err_exp = 1'b0; ovr_exp = 1'b0;
      fault_cur = 1'b0;
    end else begin
      hist_p.push_back(phase);
      hist_f.push_back(fault);
      if (acc_now && fault_cur) err_exp = 1'b1;
      else if (err_clr)         err_exp = 1'b0;
      ovr_exp = 1'b0;
      if (acc_now) begin outstanding--; beat_ch++; end
      if ((cyc % PER) == PER - 1 && (cyc / PER) >= 1) begin
        if (outstanding == 0) begin
          emit_per = cyc / PER; outstanding = NCH; beat_ch = 0;
        end else begin
          ovr_exp = 1'b1;
        end
      end
      cyc++;
    end
    #1;
    chk("valid", 32'(res_valid), 32'(outstanding > 0));
    chk("overrun", 32'(overrun), 32'(ovr_exp));
    chk("err", 32'(err), 32'(err_exp));
    fault_cur = 1'b0;
    if (outstanding > 0) begin
      model(emit_per, beat_ch, phd, frq, flt);
      chk("ch", 32'(res_ch), 32'(beat_ch));
      chk("phdiff", 32'(res_phdiff), 32'(phd));
      chk("freq", 32'(res_freq), 32'(frq));
      chk("fault", 32'(res_fault), 32'(flt));
      if (chk48 && beat_ch == 1) chk("freq48", 32'(res_freq), 32'd48);
      fault_cur = flt;
    end
    // next-cycle stimulus
    t++;
    for (int k = 0; k < NCH; k++) begin
      x = swrap(base[k] + rate[k] * t) & ((1 << DW) - 1);
      phase[k*DW +: DW] = x[DW-1:0];
    end
    ready = (($urandom % 100) < rdy_pct) && !(cyc >= lo_from && cyc < lo_to);
    fault = '0;
    if (cyc == f_at1 || cyc == f_at2) fault[2] = 1'b1;
    if (rnd_flt) for (int k = 0; k < NCH; k++) if ($urandom % 40 == 0) fault[k] = 1'b1;
    err_clr = (cyc == c_at1 || cyc == c_at2) || (rnd_flt && ($urandom % 20 == 0));
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic cfg(input int b0, b1, b2, b3, r0, r1, r2, r3);
    base[0] = b0; base[1] = b1; base[2] = b2; base[3] = b3;
    rate[0] = r0; rate[1] = r1; rate[2] = r2; rate[3] = r3;
    t = 0; rdy_pct = 100; lo_from = 0; lo_to = 0;
    f_at1 = -1; f_at2 = -1; c_at1 = -1; c_at2 = -1; rnd_flt = 0; chk48 = 0;
  endtask

  task automatic cfg_rand(input int maxr);
    cfg(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < NCH; k++) begin
      base[k] = int'($urandom % (1 << DW));
      rate[k] = int'($urandom % (2 * maxr + 1)) - maxr;
    end
  endtask

  initial begin
    // reset state and constant phases
    cfg(100, 150, 16300, 100, 0, 0, 0, 0);
    do_reset();
    chk("rst_ch", 32'(res_ch), 32'd0);
    chk("rst_phdiff", 32'(res_phdiff), 32'd0);
    chk("rst_freq", 32'(res_freq), 32'd0);
    chk("rst_fault", 32'(res_fault), 32'd0);
    run_to(31);
    chk("warm_quiet", 32'(res_valid), 32'd0);
    step();
    chk("first_beat", 32'({res_valid, res_ch}), 32'({1'b1, 2'd0}));
    step();
    chk("const_ph1", 32'(res_phdiff), 32'd50);
    step();
    chk("const_ph2", 32'(res_phdiff), 32'(14'h3F48));
    chk("const_fq2", 32'(res_freq), 32'd0);
    run_to(70);

    // ch1 ramps through the wrap
    cfg(100, 16300, 200, 300, 0, 3, 0, 0);
    chk48 = 1;
    do_reset();
    run_to(100);

    // stalled readout causes one dropped period
    cfg_rand(60);
    lo_from = 32; lo_to = 52;
    do_reset();
    run_to(48);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_frozen", 32'(res_ch), 32'd0);
    run_to(100);

    // fault pulse, err stickiness, coincident clear
    cfg_rand(40);
    f_at1 = 20; f_at2 = 52; c_at1 = 40; c_at2 = 66;
    do_reset();
    run_to(35);
    chk("err_set", 32'(err), 32'd1);
    run_to(41);
    chk("err_clr", 32'(err), 32'd0);
    run_to(67);
    chk("err_wins", 32'(err), 32'd1);
    run_to(80);

    // reset during the ch1 beat
    cfg_rand(100);
    do_reset();
    run_to(33);
    chk("pre_rst_ch", 32'(res_ch), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid", 32'(res_valid), 32'd0);
    run_to(31);
    chk("rst_quiet", 32'(res_valid), 32'd0);
    step();
    chk("rst_rebeat", 32'(res_valid), 32'd1);

    // randomized: light and heavy back-pressure, random faults/clears
    cfg_rand(2000);
    rdy_pct = 60; rnd_flt = 1;
    do_reset();
    run_to(220);
    cfg_rand(8000);
    rdy_pct = 15; rnd_flt = 1;
    do_reset();
    run_to(200);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
